// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave bus plus DMA request handshake for the ahb_slave_mem peripheral.
// The master modport is the DMAC/bus side; the slave modport is the memory side.
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADYIN;
    logic [31:0] HWDATA;
    logic [3:0]  WSTRB;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic        trigger;
    logic        DmacReq;
    logic        ReqAck;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADYIN, HWDATA, WSTRB,
        input  trigger, ReqAck,
        output HRDATA, HREADYOUT, HRESP, DmacReq
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADYIN, HWDATA, WSTRB,
        output trigger, ReqAck,
        input  HRDATA, HREADYOUT, HRESP, DmacReq
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite byte-addressed memory slave with programmable wait states, byte-strobe
// writes, a two-cycle ERROR response and a trigger/ack driven DMA request line.
module ahb_slave_mem #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input logic            HCLK,
    input logic            HRESET,
    ahb_slave_mem_if.slave bus
);
    localparam int         AW        = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e          state_q;
    logic [3:0]      wcnt_q;
    logic [AW-1:0]   idx_q;
    logic            write_q;
    logic            hready_q;
    logic [1:0]      hresp_q;
    logic            req_q;

    logic [7:0]      mem [0:MEM_DEPTH-1];

    logic [AW-1:0]   idx_d;
    logic            accept;
    logic            err_d;
    logic [31:0]     rdata;

    // Address-phase decode; only states that end a data phase can take a new transfer.
    always_comb begin
        idx_d  = bus.HADDR[AW-1:0];
        accept = ((state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2)) &&
                 bus.HSEL && bus.HREADYIN && bus.HTRANS[1];
        err_d  = (bus.HSIZE > 3'b010) ||
                 ((bus.HSIZE == 3'b001) && idx_d[0]) ||
                 ((bus.HSIZE == 3'b010) && (idx_d[1:0] != 2'b00));
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE, S_DATA, S_ERR2: begin
                    if (accept) begin
                        idx_q   <= idx_d;
                        write_q <= bus.HWRITE;
                        wcnt_q  <= 4'd0;
                        if (err_d) begin
                            state_q  <= S_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= 2'b01;
                        end else if (WAIT_STATES > 0) begin
                            state_q  <= S_WAIT;
                            hready_q <= 1'b0;
                            hresp_q  <= 2'b00;
                        end else begin
                            state_q  <= S_DATA;
                            hready_q <= 1'b1;
                            hresp_q  <= 2'b00;
                        end
                    end else begin
                        state_q  <= S_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 2'b00;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == WAIT_LAST) begin
                        state_q  <= S_DATA;
                        wcnt_q   <= 4'd0;
                        hready_q <= 1'b1;
                        hresp_q  <= 2'b00;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                S_ERR1: begin
                    state_q  <= S_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 2'b01;
                end
                default: begin
                    state_q  <= S_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= 2'b00;
                end
            endcase
        end
    end

    // ReqAck has priority so a simultaneous trigger cannot re-arm the request.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            req_q <= 1'b0;
        end else if (bus.ReqAck) begin
            req_q <= 1'b0;
        end else if (bus.trigger) begin
            req_q <= 1'b1;
        end
    end

    // Storage is not reset so contents survive HRESET; writes commit at the edge ending DATA.
    always @(posedge HCLK) begin
        if (!HRESET && (state_q == S_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.WSTRB[i]) begin
                    mem[{idx_q[AW-1:2], 2'(i)}] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if ((state_q == S_DATA) && !write_q) begin
            rdata = {mem[{idx_q[AW-1:2], 2'd3}], mem[{idx_q[AW-1:2], 2'd2}],
                     mem[{idx_q[AW-1:2], 2'd1}], mem[{idx_q[AW-1:2], 2'd0}]};
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = hready_q;
    assign bus.HRESP     = hresp_q;
    assign bus.DmacReq   = req_q;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one zero-wait and one two-wait instance share
// the bus stimulus, each selected by its own HSEL.
module tb_ahb_slave_mem;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] SZ_HALF  = 3'b001;
    localparam logic [2:0] SZ_WORD  = 3'b010;

    logic        clk;
    logic        rst;
    logic        sel0, sel2;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        trig;
    logic        ack;

    int errorCount = 0;
    int checkCount = 0;

    ahb_slave_mem_if bus0 ();
    ahb_slave_mem_if bus2 ();

    assign bus0.HSEL     = sel0;
    assign bus0.HADDR    = addr;
    assign bus0.HTRANS   = trans;
    assign bus0.HWRITE   = write;
    assign bus0.HSIZE    = size;
    assign bus0.HREADYIN = bus0.HREADYOUT;
    assign bus0.HWDATA   = wdata;
    assign bus0.WSTRB    = strb;
    assign bus0.trigger  = trig;
    assign bus0.ReqAck   = ack;

    assign bus2.HSEL     = sel2;
    assign bus2.HADDR    = addr;
    assign bus2.HTRANS   = trans;
    assign bus2.HWRITE   = write;
    assign bus2.HSIZE    = size;
    assign bus2.HREADYIN = bus2.HREADYOUT;
    assign bus2.HWDATA   = wdata;
    assign bus2.WSTRB    = strb;
    assign bus2.trigger  = trig;
    assign bus2.ReqAck   = ack;

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus0.slave)
    );

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s0, input logic s2, input logic [31:0] a,
                                 input logic [1:0] t, input logic w, input logic [2:0] sz);
        sel0  = s0;
        sel2  = s2;
        addr  = a;
        trans = t;
        write = w;
        size  = sz;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 32'h0, T_IDLE, 1'b0, 3'b000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        wdata = 32'h0;
        strb  = 4'h0;
        trig  = 1'b0;
        ack   = 1'b0;
        applyIdle();
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rst_ready0", {31'd0, bus0.HREADYOUT}, 32'd1);
        checkOutput("rst_resp0",  {30'd0, bus0.HRESP},     32'd0);
        checkOutput("rst_rdata0", bus0.HRDATA,             32'd0);
        checkOutput("rst_req0",   {31'd0, bus0.DmacReq},   32'd0);
        checkOutput("rst_ready2", {31'd0, bus2.HREADYOUT}, 32'd1);

        dut0.mem[0]  <= 8'h00; dut0.mem[1]  <= 8'h02; dut0.mem[2]  <= 8'h04; dut0.mem[3]  <= 8'h06;
        for (int i = 8; i < 16; i++) dut0.mem[i] <= 8'(i);
        dut2.mem[4]  <= 8'h11; dut2.mem[5]  <= 8'h22; dut2.mem[6]  <= 8'h33; dut2.mem[7]  <= 8'h44;
        dut2.mem[32] <= 8'hAA; dut2.mem[33] <= 8'hBB; dut2.mem[34] <= 8'hCC; dut2.mem[35] <= 8'hDD;
        tick();
        rst = 1'b0;

        // Zero-wait single read
        applyStimulus(1'b1, 1'b0, 32'h0, T_NONSEQ, 1'b0, SZ_WORD);
        tick();
        applyIdle();
        checkOutput("t1_rdata", bus0.HRDATA,             32'h06040200);
        checkOutput("t1_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
        checkOutput("t1_resp",  {30'd0, bus0.HRESP},     32'd0);
        tick();
        checkOutput("t1_idle_rdata", bus0.HRDATA, 32'd0);

        // Two-wait write with partial strobes
        applyStimulus(1'b0, 1'b1, 32'h1004, T_NONSEQ, 1'b1, SZ_WORD);
        tick();
        applyIdle();
        wdata = 32'hDEADBEEF;
        strb  = 4'b0011;
        checkOutput("t2_wait1", {31'd0, bus2.HREADYOUT}, 32'd0);
        tick();
        checkOutput("t2_wait2", {31'd0, bus2.HREADYOUT}, 32'd0);
        tick();
        checkOutput("t2_data_ready", {31'd0, bus2.HREADYOUT}, 32'd1);
        checkOutput("t2_data_resp",  {30'd0, bus2.HRESP},     32'd0);
        tick();
        strb  = 4'b0000;
        wdata = 32'h0;
        checkOutput("t2_mem", {dut2.mem[7], dut2.mem[6], dut2.mem[5], dut2.mem[4]}, 32'h4433BEEF);

        // Back-to-back NONSEQ + SEQ reads
        applyStimulus(1'b1, 1'b0, 32'h8, T_NONSEQ, 1'b0, SZ_WORD);
        tick();
        checkOutput("t3_rdata8", bus0.HRDATA,             32'h0B0A0908);
        checkOutput("t3_ready8", {31'd0, bus0.HREADYOUT}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'hC, T_SEQ, 1'b0, SZ_WORD);
        tick();
        applyIdle();
        checkOutput("t3_rdataC", bus0.HRDATA,             32'h0F0E0D0C);
        checkOutput("t3_readyC", {31'd0, bus0.HREADYOUT}, 32'd1);
        tick();
        checkOutput("t3_idle_rdata", bus0.HRDATA, 32'd0);

        // Write immediately followed by read-back of the same word
        applyStimulus(1'b1, 1'b0, 32'h10, T_NONSEQ, 1'b1, SZ_WORD);
        tick();
        wdata = 32'hA55A3CC3;
        strb  = 4'b1111;
        applyStimulus(1'b1, 1'b0, 32'h10, T_NONSEQ, 1'b0, SZ_WORD);
        tick();
        applyIdle();
        strb = 4'b0000;
        checkOutput("wr_rd_rdata", bus0.HRDATA, 32'hA55A3CC3);
        tick();

        // WSTRB=0 leaves memory untouched
        applyStimulus(1'b1, 1'b0, 32'h10, T_NONSEQ, 1'b1, SZ_WORD);
        tick();
        applyIdle();
        wdata = 32'hFFFFFFFF;
        tick();
        wdata = 32'h0;
        checkOutput("strb0_mem", {dut0.mem[19], dut0.mem[18], dut0.mem[17], dut0.mem[16]}, 32'hA55A3CC3);

        // Misaligned word read -> two-cycle ERROR
        applyStimulus(1'b1, 1'b0, 32'h2, T_NONSEQ, 1'b0, SZ_WORD);
        tick();
        applyIdle();
        checkOutput("t4_err1_ready", {31'd0, bus0.HREADYOUT}, 32'd0);
        checkOutput("t4_err1_resp",  {30'd0, bus0.HRESP},     32'd1);
        checkOutput("t4_err1_rdata", bus0.HRDATA,             32'd0);
        tick();
        checkOutput("t4_err2_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
        checkOutput("t4_err2_resp",  {30'd0, bus0.HRESP},     32'd1);
        tick();
        checkOutput("t4_after_resp", {30'd0, bus0.HRESP}, 32'd0);

        // Oversize write -> ERROR, no memory change
        applyStimulus(1'b1, 1'b0, 32'h0, T_NONSEQ, 1'b1, 3'b011);
        tick();
        applyIdle();
        wdata = 32'hFFFFFFFF;
        strb  = 4'b1111;
        checkOutput("t4b_err1_resp",  {30'd0, bus0.HRESP},     32'd1);
        checkOutput("t4b_err1_ready", {31'd0, bus0.HREADYOUT}, 32'd0);
        tick();
        checkOutput("t4b_err2_resp",  {30'd0, bus0.HRESP},     32'd1);
        checkOutput("t4b_err2_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
        tick();
        strb  = 4'b0000;
        wdata = 32'h0;
        checkOutput("t4b_mem", {dut0.mem[3], dut0.mem[2], dut0.mem[1], dut0.mem[0]}, 32'h06040200);

        // Misaligned halfword -> ERROR
        applyStimulus(1'b1, 1'b0, 32'h1, T_NONSEQ, 1'b0, SZ_HALF);
        tick();
        applyIdle();
        checkOutput("half_err_resp", {30'd0, bus0.HRESP}, 32'd1);
        tick();
        tick();

        // DmacReq set / drop / ack / simultaneous
        trig = 1'b1;
        tick();
        trig = 1'b0;
        checkOutput("t5_set", {31'd0, bus0.DmacReq}, 32'd1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        checkOutput("t5_second_trig", {31'd0, bus0.DmacReq}, 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("t5_ack", {31'd0, bus0.DmacReq}, 32'd0);
        trig = 1'b1;
        ack  = 1'b1;
        tick();
        trig = 1'b0;
        ack  = 1'b0;
        checkOutput("t5_both", {31'd0, bus0.DmacReq}, 32'd0);
        tick();
        checkOutput("t5_no_queue", {31'd0, bus0.DmacReq}, 32'd0);

        // Reset asserted mid-WAIT of a write
        trig = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h20, T_NONSEQ, 1'b1, SZ_WORD);
        tick();
        trig = 1'b0;
        applyIdle();
        wdata = 32'h11223344;
        strb  = 4'b1111;
        checkOutput("t6_wait_ready", {31'd0, bus2.HREADYOUT}, 32'd0);
        checkOutput("t6_req_before", {31'd0, bus2.DmacReq},   32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_ready", {31'd0, bus2.HREADYOUT}, 32'd1);
        checkOutput("t6_rst_resp",  {30'd0, bus2.HRESP},     32'd0);
        checkOutput("t6_rst_rdata", bus2.HRDATA,             32'd0);
        checkOutput("t6_rst_req",   {31'd0, bus2.DmacReq},   32'd0);
        tick();
        rst   = 1'b0;
        strb  = 4'b0000;
        wdata = 32'h0;
        checkOutput("t6_mem", {dut2.mem[35], dut2.mem[34], dut2.mem[33], dut2.mem[32]}, 32'hDDCCBBAA);
        applyStimulus(1'b0, 1'b1, 32'h20, T_NONSEQ, 1'b0, SZ_WORD);
        tick();
        applyIdle();
        tick();
        tick();
        checkOutput("t6_read_rdata", bus2.HRDATA,             32'hDDCCBBAA);
        checkOutput("t6_read_resp",  {30'd0, bus2.HRESP},     32'd0);
        checkOutput("t6_read_ready", {31'd0, bus2.HREADYOUT}, 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
